apb_req_arbiter: RTL and testbench
==================================

Name: apb_req_arbiter

Overview:
Round-robin scheduler that shares the single APB master command port between NREQ local requesters.
- Picks one pending request, latches its command and drives the master's transfer/direction/address/data inputs.
- Watches the APB bus for completion, captures read data and returns a one-cycle acknowledge to the winning requester.
- Sits between the client logic and APB_MASTER in the peripheral subsystem.

Parameters:
NREQ, 2, number of requesters (2..4)
AW, 8, APB address width
DW, 8, APB data width

Ports:
pclk  in  1  clock, rising edge
prst  in  1  reset, synchronous, active-high
req  in  NREQ  request level per requester; held until its ack
req_write  in  NREQ  1 = write, 0 = read, per requester
req_addr  in  NREQ*AW  packed addresses, requester i at bits [i*AW +: AW]
req_wdata  in  NREQ*DW  packed write data, same packing
ack  out  NREQ  one-cycle completion pulse, one-hot
rdata  out  DW  read data; valid in the ack cycle of a read
grant_id  out  2  index of the current/last granted requester
busy  out  1  transfer in flight (state XFER or RESP)
m_ptransfer  out  1  to master ptransfer
m_pread_write  out  1  to master pread_write
m_write_paddr  out  AW  to master apb_write_paddr
m_read_paddr  out  AW  to master apb_read_paddr
m_write_data  out  DW  to master apb_write_data
psel  in  1  APB bus monitor
penable  in  1  APB bus monitor
pready  in  1  APB bus monitor
prdata  in  DW  APB bus monitor

Behaviour:
- Reset (prst=1 at a pclk edge):
  - state=IDLE; ack=0, rdata=0, grant_id=NREQ-1, busy=0.
  - All m_* outputs are 0.
  - Reset mid-transfer abandons the transfer and sends no ack; the master is reset by the same prst.
- State machine: IDLE, XFER, RESP.
- IDLE:
  - If any req bit is set, the winner is the first set bit searching upward, modulo NREQ, from grant_id+1.
  - Latch winner's write/addr/wdata into command registers, set grant_id=winner, go to XFER.
  - With no req, stay in IDLE.
- XFER:
  - m_ptransfer = 1 & ~(psel & penable & pready). This is the only combinational output; it drops in the completion cycle so the master returns to idle after one transfer.
  - m_pread_write = latched write.
  - Address is driven on both m_write_paddr and m_read_paddr.
  - m_write_data = latched wdata.
  - On an edge with psel&penable&pready=1: capture prdata into rdata on reads (rdata holds its old value on writes) and go to RESP.
  - Wait states (pready=0) are unbounded; the state holds.
- RESP: ack[grant_id]=1 for exactly this cycle, m_ptransfer=0, go to IDLE.
- Spacing: a new grant is decided in IDLE only, so back-to-back transfers have at least 2 idle pclk cycles between completions. Each requester sees at most one transfer per ack.
- Command stability:
  - Latched command registers are stable from grant to ack; requester inputs may change after grant without effect.
  - A req dropped before its grant is simply never served; no error.
- Fairness: with all requesters pending continuously, grants rotate 0,1,…,NREQ-1,0. Maximum wait is NREQ-1 transfers.
- Simultaneous events: a new req arriving in the RESP cycle is arbitrated in the following IDLE cycle. The requester just acked is lowest priority there.

Decomposition:
- Shared package apb_pkg: state encodings (IDLE/XFER/RESP), AW/DW defaults, the APB phase constants idle/setup/access already used by the master.
- One sub-module, rr_pick: combinational round-robin picker with inputs req[NREQ] and last[1:0], outputs valid and idx[1:0]. It is reusable by later APB arbiters.

Test Plan:
- Reset: hold prst 2 cycles with req=2'b11 → ack=0, m_ptransfer=0, grant_id=1, busy=0; first grant after release goes to requester 0.
- Single write: req[0]=1, write=1, addr=8'h12, wdata=8'hA5, pready=1 → m_write_paddr=8'h12, m_write_data=8'hA5; ack[0] pulses one cycle after the psel&penable&pready edge; m_ptransfer is 0 in the completion cycle.
- Read with 3 wait states: req[1] read addr=8'h40, pready low 3 access cycles, prdata=8'h3C → busy held throughout; ack[1]=1 with rdata=8'h3C.
- Fairness: req=2'b11 held for 4 transfers → grant_id sequence 0,1,0,1; exactly one ack pulse per transfer.
- Mid-transfer reset: assert prst during XFER wait state → next cycle state IDLE, all outputs 0, no ack.
- Late request: req[1] rises in the RESP cycle of requester 0 while req[0] stays high → requester 1 is granted next.

Source files
------------

// File: rtl/apb_pkg.sv
// apb_pkg: definitions shared by the APB subsystem blocks.
//   - Default APB address/data widths.
//   - APB bus phase encoding (idle/setup/access) as used by the APB master.
//   - Request arbiter state encoding and requester index width.
package apb_pkg;

   // Default APB bus widths.
   localparam int unsigned ApbAddrWidth = 8;
   localparam int unsigned ApbDataWidth = 8;

   // Requester indices are carried on 2 bits, so at most 4 requesters.
   localparam int unsigned ReqIdxW = 2;
   localparam int unsigned MaxReq  = 4;

   // APB bus phases as seen by the master.
   typedef enum logic [1:0] {
      ApbPhIdle   = 2'd0,
      ApbPhSetup  = 2'd1,
      ApbPhAccess = 2'd2
   } apb_phase_e;

   // Request arbiter states.
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StXfer = 2'd1,
      StResp = 2'd2
   } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req_i   : pending request per requester
//   last_i  : index of the previously granted requester
//   valid_o : at least one request is pending
//   idx_o   : first pending requester searching upward, modulo NREQ, from last_i+1
// The previously granted requester is therefore the lowest priority.
module rr_pick
   import apb_pkg::*;
#(
   parameter int unsigned NREQ = 2
) (
   input  logic [NREQ-1:0]    req_i,
   input  logic [ReqIdxW-1:0] last_i,
   output logic               valid_o,
   output logic [ReqIdxW-1:0] idx_o
);

   localparam int N = int'(NREQ);

   always_comb begin
      valid_o = 1'b0;
      idx_o   = '0;
      // Walk distances from farthest to nearest so the nearest pending requester is written last
      // and wins.
      for (int k = N; k >= 1; k--) begin
         for (int i = 0; i < N; i++) begin
            if (req_i[i] && (i == ((int'(last_i) + k) % N))) begin
               valid_o = 1'b1;
               idx_o   = ReqIdxW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: shares one APB master command port between NREQ local requesters.
//   pclk, prst            : clock and synchronous active-high reset
//   req/req_write         : per-requester request level (held until ack) and direction (1 = write)
//   req_addr/req_wdata    : packed per-requester address / write data, requester i at [i*W +: W]
//   ack                   : one-cycle one-hot completion pulse
//   rdata                 : read data, valid in the ack cycle of a read
//   grant_id              : current/last granted requester
//   busy                  : transfer in flight
//   m_ptransfer ...       : command to the APB master (transfer, direction, addresses, write data)
//   psel/penable/pready   : APB bus monitor, completion is psel & penable & pready
//   prdata                : APB read data monitor
// A grant is only decided in IDLE, so each transfer is followed by a RESP cycle (ack) and an
// IDLE cycle before the next one begins.
module apb_req_arbiter
   import apb_pkg::*;
#(
   parameter int unsigned NREQ = 2,
   parameter int unsigned AW   = ApbAddrWidth,
   parameter int unsigned DW   = ApbDataWidth
) (
   input  logic              pclk,
   input  logic              prst,
   input  logic [NREQ-1:0]    req,
   input  logic [NREQ-1:0]    req_write,
   input  logic [NREQ*AW-1:0] req_addr,
   input  logic [NREQ*DW-1:0] req_wdata,
   output logic [NREQ-1:0]    ack,
   output logic [DW-1:0]      rdata,
   output logic [1:0]         grant_id,
   output logic               busy,
   output logic               m_ptransfer,
   output logic               m_pread_write,
   output logic [AW-1:0]      m_write_paddr,
   output logic [AW-1:0]      m_read_paddr,
   output logic [DW-1:0]      m_write_data,
   input  logic               psel,
   input  logic               penable,
   input  logic               pready,
   input  logic [DW-1:0]      prdata
);

   arb_state_e         state_q, state_d;
   logic [ReqIdxW-1:0] grant_q, grant_d;
   logic               wr_q, wr_d;
   logic [AW-1:0]      addr_q, addr_d;
   logic [DW-1:0]      wdata_q, wdata_d;
   logic [DW-1:0]      rdata_q, rdata_d;
   logic [NREQ-1:0]    ack_q, ack_d;

   logic               pick_valid;
   logic [ReqIdxW-1:0] pick_idx;
   logic               win_write;
   logic [AW-1:0]      win_addr;
   logic [DW-1:0]      win_wdata;
   logic               bus_done;

   assign bus_done = psel & penable & pready;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .req_i   (req),
      .last_i  (grant_q),
      .valid_o (pick_valid),
      .idx_o   (pick_idx)
   );

   // Winner's command fields, muxed out of the packed request buses.
   always_comb begin
      win_write = 1'b0;
      win_addr  = '0;
      win_wdata = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (pick_idx == ReqIdxW'(i)) begin
            win_write = req_write[i];
            win_addr  = req_addr[i*AW +: AW];
            win_wdata = req_wdata[i*DW +: DW];
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      wr_d        = wr_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      rdata_d     = rdata_q;
      ack_d       = '0;
      m_ptransfer = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (pick_valid) begin
               grant_d = pick_idx;
               wr_d    = win_write;
               addr_d  = win_addr;
               wdata_d = win_wdata;
               state_d = StXfer;
            end
         end

         StXfer: begin
            // Drop the request in the completion cycle so the master idles after one transfer.
            m_ptransfer = ~bus_done;
            if (bus_done) begin
               if (!wr_q) begin
                  rdata_d = prdata;
               end
               for (int i = 0; i < int'(NREQ); i++) begin
                  ack_d[i] = (grant_q == ReqIdxW'(i));
               end
               state_d = StResp;
            end
         end

         StResp: begin
            state_d = StIdle;
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q <= StIdle;
         grant_q <= ReqIdxW'(NREQ - 1);
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         ack_q   <= ack_d;
      end
   end

   assign ack           = ack_q;
   assign rdata         = rdata_q;
   assign grant_id      = grant_q;
   assign busy          = (state_q != StIdle);
   // Latched command is held after the transfer; the master only acts on it with m_ptransfer.
   assign m_pread_write = wr_q;
   assign m_write_paddr = addr_q;
   assign m_read_paddr  = addr_q;
   assign m_write_data  = wdata_q;

   // Sanity properties.
   ack_onehot_a: assert property (@(posedge pclk) disable iff (prst) $onehot0(ack));
   ack_in_resp_a: assert property (@(posedge pclk) disable iff (prst) (|ack) |-> (state_q == StResp));
   xfer_only_busy_a: assert property (@(posedge pclk) disable iff (prst) m_ptransfer |-> busy);

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Scoreboard bench for apb_req_arbiter: a transaction-level round-robin model predicts each
// grant when the arbiter is free, and a monitor checks bus commands, acks, rdata and busy.
module tb_apb_req_arbiter;

   localparam int NREQ = 2;
   localparam int AW   = 8;
   localparam int DW   = 8;

   logic              pclk = 1'b0;
   logic              prst = 1'b1;
   logic [NREQ-1:0]    req = '0;
   logic [NREQ-1:0]    req_write = '0;
   logic [NREQ*AW-1:0] req_addr = '0;
   logic [NREQ*DW-1:0] req_wdata = '0;
   logic [NREQ-1:0]    ack;
   logic [DW-1:0]      rdata;
   logic [1:0]         grant_id;
   logic               busy;
   logic               m_ptransfer;
   logic               m_pread_write;
   logic [AW-1:0]      m_write_paddr;
   logic [AW-1:0]      m_read_paddr;
   logic [DW-1:0]      m_write_data;
   logic               psel = 1'b0;
   logic               penable = 1'b0;
   logic               pready = 1'b0;
   logic [DW-1:0]      prdata = '0;

   int checks = 0;
   int failures = 0;
   int tmo_events = 0;

   // Stimulus controls.
   int              force_waits = -1;
   int              force_rdata = -1;
   logic [NREQ-1:0] keep = '0;
   bit              gen_en = 1'b0;
   logic [NREQ-1:0] ack_s = '0;
   bit              done_s = 1'b0;

   always #5 pclk = ~pclk;

   apb_req_arbiter #(
      .NREQ (NREQ),
      .AW   (AW),
      .DW   (DW)
   ) dut (
      .pclk          (pclk),
      .prst          (prst),
      .req           (req),
      .req_write     (req_write),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .ack           (ack),
      .rdata         (rdata),
      .grant_id      (grant_id),
      .busy          (busy),
      .m_ptransfer   (m_ptransfer),
      .m_pread_write (m_pread_write),
      .m_write_paddr (m_write_paddr),
      .m_read_paddr  (m_read_paddr),
      .m_write_data  (m_write_data),
      .psel          (psel),
      .penable       (penable),
      .pready        (pready),
      .prdata        (prdata)
   );

   // ---------------------------------------------------------------- APB master + slave model
   initial begin
      int  phase = 0;  // 0 idle, 1 setup, 2 access
      int  waits = 0;
      bit  xfer_s;
      bit  rst_s;
      forever begin
         @(negedge pclk);
         xfer_s = m_ptransfer;
         rst_s  = prst;
         @(posedge pclk);
         #1;
         if (rst_s) begin
            phase = 0;
         end else begin
            case (phase)
               0: if (xfer_s) phase = 1;
               1: begin
                  phase  = 2;
                  waits  = (force_waits >= 0) ? force_waits : int'($urandom_range(0, 3));
                  prdata = (force_rdata >= 0) ? DW'(force_rdata) : DW'($urandom);
               end
               default: begin
                  if (waits == 0) phase = xfer_s ? 1 : 0;
                  else waits--;
               end
            endcase
         end
         psel    = (phase != 0);
         penable = (phase == 2);
         // Outside the access phase pready is noise the arbiter must ignore.
         pready  = (phase == 2) ? (waits == 0) : 1'($urandom_range(0, 1));
      end
   end

   // ---------------------------------------------------------------- reference model + monitor
   typedef struct {
      int             idx;
      logic           wr;
      logic [AW-1:0]  addr;
      logic [DW-1:0]  wdata;
   } exp_t;

   exp_t exp_q[$];

   function automatic int rr_next(input logic [NREQ-1:0] r, input int from);
      for (int k = 1; k <= NREQ; k++) begin
         int c = (from + k) % NREQ;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin
      bit            free = 1'b1;
      bit            hold = 1'b0;
      bit            inflight = 1'b0;
      bit            prev_rst = 1'b0;
      int            last = NREQ - 1;
      int            tmo_seen = 0;
      logic [DW-1:0] exp_rdata = '0;
      exp_t          e;
      bit            done;
      bit            was_hold;
      bit            was_inflight;
      int            w;
      forever begin
         @(negedge pclk);
         if (tmo_events > tmo_seen) begin
            tmo_seen++;
            checks++;
            failures++;
            $display("FAIL wait_budget: expected DUT activity never arrived at %0t", $time);
         end
         if (prev_rst) begin
            chk("rst_ack", 32'(ack), 32'(0));
            chk("rst_busy", 32'(busy), 32'(0));
            chk("rst_grant_id", 32'(grant_id), 32'(NREQ - 1));
            chk("rst_rdata", 32'(rdata), 32'(0));
            chk("rst_ptransfer", 32'(m_ptransfer), 32'(0));
            chk("rst_pread_write", 32'(m_pread_write), 32'(0));
            chk("rst_write_paddr", 32'(m_write_paddr), 32'(0));
            chk("rst_read_paddr", 32'(m_read_paddr), 32'(0));
            chk("rst_write_data", 32'(m_write_data), 32'(0));
         end
         if (prst) begin
            exp_q.delete();
            free      = 1'b1;
            hold      = 1'b0;
            inflight  = 1'b0;
            last      = NREQ - 1;
            exp_rdata = '0;
            prev_rst  = 1'b1;
            continue;
         end
         prev_rst = 1'b0;
         done     = psel && penable && pready;

         chk("busy", 32'(busy), 32'(inflight));
         if (hold) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL resp_entry: got empty scoreboard, expected a granted request");
            end else begin
               e = exp_q.pop_front();
               chk("ack_onehot", 32'(ack), 32'(1) << e.idx);
               chk("resp_grant_id", 32'(grant_id), 32'(e.idx));
               chk("resp_rdata", 32'(rdata), 32'(exp_rdata));
               chk("resp_ptransfer", 32'(m_ptransfer), 32'(0));
            end
         end else begin
            chk("ack_quiet", 32'(ack), 32'(0));
         end

         if (inflight && !hold && exp_q.size() != 0) begin
            e = exp_q[0];
            chk("xfer_grant_id", 32'(grant_id), 32'(e.idx));
            chk("xfer_pread_write", 32'(m_pread_write), 32'(e.wr));
            chk("xfer_write_paddr", 32'(m_write_paddr), 32'(e.addr));
            chk("xfer_read_paddr", 32'(m_read_paddr), 32'(e.addr));
            chk("xfer_write_data", 32'(m_write_data), 32'(e.wdata));
            chk("xfer_ptransfer", 32'(m_ptransfer), 32'(!done));
            if (done && !e.wr) exp_rdata = prdata;
         end

         was_hold     = hold;
         was_inflight = inflight;
         if (free && (req != '0)) begin
            w       = rr_next(req, last);
            e.idx   = w;
            e.wr    = req_write[w];
            e.addr  = req_addr[w*AW +: AW];
            e.wdata = req_wdata[w*DW +: DW];
            exp_q.push_back(e);
            last     = w;
            free     = 1'b0;
            inflight = 1'b1;
         end
         if (was_hold) begin
            hold     = 1'b0;
            inflight = 1'b0;
            free     = 1'b1;
         end else if (was_inflight && done) begin
            hold = 1'b1;
         end
      end
   end

   // ---------------------------------------------------------------- requester stimulus
   task automatic step();
      logic [NREQ-1:0] a;
      @(negedge pclk);
      a      = ack;
      ack_s  = a;
      done_s = psel && penable && pready;
      @(posedge pclk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
         if (a[i] && !keep[i]) req[i] = 1'b0;
         if (gen_en) begin
            if (!req[i]) begin
               if ($urandom_range(0, 2) == 0) begin
                  req[i]                = 1'b1;
                  req_write[i]          = 1'($urandom_range(0, 1));
                  req_addr[i*AW +: AW]  = AW'($urandom);
                  req_wdata[i*DW +: DW] = DW'($urandom);
               end
            end else if ($urandom_range(0, 3) == 0) begin
               // Command inputs may wander while pending; only the grant-cycle value counts.
               req_write[i]          = 1'($urandom_range(0, 1));
               req_addr[i*AW +: AW]  = AW'($urandom);
               req_wdata[i*DW +: DW] = DW'($urandom);
            end
         end
      end
   endtask

   task automatic wait_acks(input int n, input int budget);
      int got = 0;
      int left = budget;
      while (got < n && left > 0) begin
         step();
         got += $countones(ack_s);
         left--;
      end
      if (got < n) tmo_events++;
   endtask

   task automatic drain(input int budget);
      int left = budget;
      while ((req != '0 || busy) && left > 0) begin
         step();
         left--;
      end
      if (left == 0) tmo_events++;
      repeat (2) step();
   endtask

   initial begin
      int left;
      // Reset held with both requesters pending; first grant must go to requester 0.
      prst = 1'b1;
      req  = '1;
      repeat (2) step();
      prst = 1'b0;

      // Fairness: both held continuously for 4 transfers.
      keep = '1;
      wait_acks(4, 100);
      keep = '0;
      drain(100);

      // Single write, no wait states.
      force_waits       = 0;
      req_write[0]      = 1'b1;
      req_addr[7:0]     = 8'h12;
      req_wdata[7:0]    = 8'hA5;
      req[0]            = 1'b1;
      wait_acks(1, 50);
      drain(50);

      // Read with 3 wait states.
      force_waits       = 3;
      force_rdata       = 8'h3C;
      req_write[1]      = 1'b0;
      req_addr[15:8]    = 8'h40;
      req[1]            = 1'b1;
      wait_acks(1, 50);
      force_rdata       = -1;
      drain(50);

      // Reset during an access wait state.
      force_waits       = 5;
      req_write[0]      = 1'b0;
      req_addr[7:0]     = 8'h77;
      req[0]            = 1'b1;
      repeat (4) step();
      prst              = 1'b1;
      req               = '0;
      step();
      prst              = 1'b0;
      force_waits       = -1;
      repeat (3) step();

      // Late request: requester 1 rises in requester 0's RESP cycle while 0 stays pending.
      keep              = 2'b01;
      req_write[0]      = 1'b1;
      req_wdata[7:0]    = 8'h5A;
      req[0]            = 1'b1;
      left = 50;
      done_s = 1'b0;
      while (!done_s && left > 0) begin
         step();
         left--;
      end
      if (!done_s) tmo_events++;
      req_write[1]      = 1'b1;
      req_addr[15:8]    = 8'hC3;
      req_wdata[15:8]   = 8'h81;
      req[1]            = 1'b1;
      wait_acks(2, 50);
      keep              = '0;
      drain(50);

      // Randomized traffic.
      gen_en = 1'b1;
      repeat (2500) step();
      gen_en = 1'b0;
      drain(400);

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached at %0t", $time);
      $fatal(1, "watchdog");
   end

endmodule
